// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_ctrl
// Brief    : 4-bit LED pattern sequencer with step prescaler; mode requests
//            arrive on a valid/ready handshake and apply on step boundaries.
//            Build macro LED_ACTIVE_LOW_EN inverts the led port.
// Revision : 1.0
// ============================================================================
module led_seq_ctrl #(
    parameter int               CNT_W   = 25,
    parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       cfg_valid,
    input  logic [2:0] cfg_mode,
    output logic       cfg_ready,
    input  logic       pause,
    output logic [2:0] mode,
    output logic       step_tick,
    output logic [3:0] led
);

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [2:0] MODE_OFF      = 3'd0;
    localparam logic [2:0] MODE_FLOW_L   = 3'd1;
    localparam logic [2:0] MODE_FLOW_R   = 3'd2;
    localparam logic [2:0] MODE_BLINK    = 3'd3;
    localparam logic [2:0] MODE_PINGPONG = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       pat, pat_nxt;
    logic [2:0]       mode_nxt;
    logic [2:0]       pend_mode, pend_mode_nxt;
    logic             pend_vld, pend_vld_nxt;
    dir_t             dir, dir_nxt;
    logic             tick_i;
    logic             accept;

    assign tick_i = (cnt == CNT_MAX) && !pause;
    assign accept = cfg_valid && cfg_ready;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt       <= '0;
            mode      <= MODE_OFF;
            pat       <= 4'b0000;
            step_tick <= 1'b0;
            pend_vld  <= 1'b0;
            pend_mode <= MODE_OFF;
            dir       <= DIR_UP;
            cfg_ready <= 1'b1;
        end else begin
            cnt       <= cnt_nxt;
            mode      <= mode_nxt;
            pat       <= pat_nxt;
            step_tick <= tick_i;
            pend_vld  <= pend_vld_nxt;
            pend_mode <= pend_mode_nxt;
            dir       <= dir_nxt;
            cfg_ready <= !pend_vld_nxt;
        end
    end

    always_comb begin
        cnt_nxt       = cnt;
        pat_nxt       = pat;
        mode_nxt      = mode;
        dir_nxt       = dir;
        pend_vld_nxt  = pend_vld;
        pend_mode_nxt = pend_mode;

        if (!pause) begin
            cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + CNT_ONE;
        end

        if (tick_i) begin
            if (pend_vld) begin
                // Apply loads the initial pattern; reserved codes collapse to OFF.
                pend_vld_nxt = 1'b0;
                dir_nxt      = DIR_UP;
                case (pend_mode)
                    MODE_FLOW_L:   begin mode_nxt = MODE_FLOW_L;   pat_nxt = 4'b0001; end
                    MODE_FLOW_R:   begin mode_nxt = MODE_FLOW_R;   pat_nxt = 4'b1000; end
                    MODE_BLINK:    begin mode_nxt = MODE_BLINK;    pat_nxt = 4'b1111; end
                    MODE_PINGPONG: begin mode_nxt = MODE_PINGPONG; pat_nxt = 4'b0001; end
                    default:       begin mode_nxt = MODE_OFF;      pat_nxt = 4'b0000; end
                endcase
            end else begin
                case (mode)
                    MODE_FLOW_L: pat_nxt = {pat[2:0], pat[3]};
                    MODE_FLOW_R: pat_nxt = {pat[0], pat[3:1]};
                    MODE_BLINK:  pat_nxt = ~pat;
                    MODE_PINGPONG: begin
                        if (dir == DIR_UP) begin
                            if (pat == 4'b1000) begin
                                pat_nxt = 4'b0100;
                                dir_nxt = DIR_DOWN;
                            end else begin
                                pat_nxt = {pat[2:0], 1'b0};
                            end
                        end else begin
                            if (pat == 4'b0001) begin
                                pat_nxt = 4'b0010;
                                dir_nxt = DIR_UP;
                            end else begin
                                pat_nxt = {1'b0, pat[3:1]};
                            end
                        end
                    end
                    default: pat_nxt = 4'b0000;
                endcase
            end
        end

        // Accept and apply are exclusive: accept needs pend_vld low, apply needs it high.
        if (accept) begin
            pend_vld_nxt  = 1'b1;
            pend_mode_nxt = cfg_mode;
        end
    end

`ifdef LED_ACTIVE_LOW_EN
    assign led = ~pat;
`else
    assign led = pat;
`endif

endmodule
`default_nettype wire
